// File: rtl/sram_like_arbiter.sv
// ----------------------------------------------------------------------------
// sram_like_arbiter: one sram-like port shared by fetch and data, data first,
// fetch protected by a starvation counter.                         Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sram_like_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state;
  logic             owner;       // 0 = fetch, 1 = data
  logic [CNT_W-1:0] starve_cnt;
  logic             grant_data;

  always_comb begin
    grant_data = data_sram_req && !(inst_sram_req && (starve_cnt == LIMIT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inst_sram_req || data_sram_req) begin
            owner <= grant_data;
            state <= ADDR;
            // Only data wins that pass over a waiting fetch count toward starvation.
            if (grant_data && inst_sram_req) begin
              if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + CNT_W'(1);
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        ADDR: if (mem_addr_ok) state <= DATA;
        DATA: if (mem_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req           = 1'b0;
    mem_wr            = 1'b0;
    mem_size          = 2'd0;
    mem_addr          = 32'd0;
    mem_wdata         = 32'd0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'd0;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'd0;
    if (state == ADDR) begin
      mem_req = 1'b1;
      if (owner) begin
        mem_wr            = data_sram_wr;
        mem_size          = data_sram_size;
        mem_addr          = data_sram_addr;
        mem_wdata         = data_sram_wdata;
        data_sram_addr_ok = mem_addr_ok;
      end else begin
        mem_size          = 2'd2;
        mem_addr          = inst_sram_addr;
        inst_sram_addr_ok = mem_addr_ok;
      end
    end else if (state == DATA && mem_data_ok) begin
      if (owner) begin
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = mem_rdata;
      end else begin
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = mem_rdata;
      end
    end
  end

  // A granted requester must keep its request up until the bridge accepts it.
  a_req_held: assert property (@(posedge clk) disable iff (reset)
    (state == ADDR) |-> (owner ? data_sram_req : inst_sram_req));

endmodule

`default_nettype wire
